// File: rtl/vga_grid_pkg.sv
// Shared constants and helpers for the VGA grid engine: default timing, colours,
// and the arithmetic used to derive line/frame totals and sync windows.
package vga_grid_pkg;

  localparam int COORD_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_GRID_N   = 3;

  localparam logic [11:0] DEF_CURSOR_COLOR = 12'hFFF;
  localparam logic [11:0] DEF_BG_COLOR     = 12'h000;

  function automatic int line_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int sync_first(input int active, input int fp);
    return active + fp;
  endfunction

  function automatic int sync_last(input int active, input int fp, input int sync);
    return active + fp + sync - 1;
  endfunction

  // Index widths never collapse to zero bits, even for a 1-wide grid.
  function automatic int min_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_H_TOTAL = line_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = line_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
  localparam int DEF_IDX_W   = min_clog2(DEF_GRID_N * DEF_GRID_N);

endpackage

// File: rtl/vga_grid_engine_timing.sv
// Pixel divider, H/V counters and registered sync/video/coordinate outputs.
// Raw counters are exported so the grid renderer can run in lockstep.
module vga_timing_gen
  import vga_grid_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int PIX_DIV  = 4
)(
  input  logic               i_clk,
  input  logic               i_rst_n,
  output logic               o_p_tick,
  output logic               o_frame_start,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_video_on,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic [COORD_W-1:0] o_h_cnt,
  output logic [COORD_W-1:0] o_v_cnt
);
  localparam int DIV_W = min_clog2(PIX_DIV);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(line_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(line_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
  localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(sync_first(H_ACTIVE, H_FP));
  localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(sync_last(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(sync_first(V_ACTIVE, V_FP));
  localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(sync_last(V_ACTIVE, V_FP, V_SYNC));
  localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);

  logic [DIV_W-1:0]   r_div;
  logic [COORD_W-1:0] r_h, r_v, r_x, r_y;
  logic               r_hsync, r_vsync, r_video_on;
  logic               w_tick;

  assign w_tick = (r_div == DIV_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) begin
        if (r_h == H_LAST) begin
          r_h <= '0;
          r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
        end else begin
          r_h <= r_h + 1'b1;
        end
      end
    end
  end

  // Outputs describe the pixel the counters pointed at on the last tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hsync    <= 1'b1;
      r_vsync    <= 1'b1;
      r_video_on <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
    end else if (w_tick) begin
      r_hsync    <= !((r_h >= HS_FIRST) && (r_h <= HS_LAST));
      r_vsync    <= !((r_v >= VS_FIRST) && (r_v <= VS_LAST));
      r_video_on <= (r_h < H_ACT) && (r_v < V_ACT);
      r_x        <= r_h;
      r_y        <= r_v;
    end
  end

  assign o_p_tick      = w_tick;
  assign o_frame_start = w_tick && (r_h == '0) && (r_v == V_ACT);
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_video_on    = r_video_on;
  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_h_cnt       = r_h;
  assign o_v_cnt       = r_v;
endmodule

// File: rtl/vga_grid_engine.sv
// VGA grid renderer: cell colour table, wrap-around cursor, select handshake.
// Define VGA_GRID_BLINK_EN to blink the cursor outline (16 frames on / 16 off).
module vga_grid_engine
  import vga_grid_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter int PIX_DIV   = 4,
  parameter int GRID_COLS = 3,
  parameter int GRID_ROWS = 3,
  parameter int CELL_W    = 213,
  parameter int CELL_H    = 160,
  parameter int BORDER    = 2,
  parameter int RGB_W     = 12,
  parameter logic [RGB_W-1:0] CURSOR_COLOR = RGB_W'(DEF_CURSOR_COLOR),
  parameter logic [RGB_W-1:0] BG_COLOR     = RGB_W'(DEF_BG_COLOR),
  localparam int N_CELLS = GRID_COLS * GRID_ROWS,
  localparam int IDX_W   = min_clog2(N_CELLS),
  localparam int COL_W   = min_clog2(GRID_COLS),
  localparam int ROW_W   = min_clog2(GRID_ROWS)
)(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_left,
  input  logic               i_right,
  input  logic               i_up,
  input  logic               i_down,
  input  logic               i_sel,
  input  logic               i_cell_we,
  input  logic [IDX_W-1:0]   i_cell_idx,
  input  logic [RGB_W-1:0]   i_cell_color,
  input  logic               i_sel_ready,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_video_on,
  output logic               o_p_tick,
  output logic               o_frame_start,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic [RGB_W-1:0]   o_rgb,
  output logic [COL_W-1:0]   o_cursor_col,
  output logic [ROW_W-1:0]   o_cursor_row,
  output logic               o_sel_valid,
  output logic [IDX_W-1:0]   o_sel_idx
);
  localparam logic [COORD_W-1:0] H_LAST  = COORD_W'(line_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
  localparam logic [COORD_W-1:0] V_LAST  = COORD_W'(line_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
  localparam logic [COORD_W-1:0] H_ACT   = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT   = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] GRID_WP = COORD_W'(GRID_COLS * CELL_W);
  localparam logic [COORD_W-1:0] GRID_HP = COORD_W'(GRID_ROWS * CELL_H);
  localparam logic [COORD_W-1:0] CW_LAST = COORD_W'(CELL_W - 1);
  localparam logic [COORD_W-1:0] CH_LAST = COORD_W'(CELL_H - 1);
  localparam logic [COORD_W-1:0] BRD     = COORD_W'(BORDER);
  localparam logic [COORD_W-1:0] CW_HI   = COORD_W'(CELL_W - BORDER);
  localparam logic [COORD_W-1:0] CH_HI   = COORD_W'(CELL_H - BORDER);
  localparam logic [COL_W-1:0]   COL_LAST = COL_W'(GRID_COLS - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST = ROW_W'(GRID_ROWS - 1);

  logic               w_tick, w_frame_start;
  logic [COORD_W-1:0] w_h, w_v;
  logic [COORD_W-1:0] r_gcol, r_goff, r_grow, r_roff;
  logic [RGB_W-1:0]   r_tab [N_CELLS];
  logic [RGB_W-1:0]   r_rgb, w_pix;
  logic [COL_W-1:0]   r_col, r_disp_col;
  logic [ROW_W-1:0]   r_row, r_disp_row;
  logic               r_sel_valid;
  logic [IDX_W-1:0]   r_sel_idx, w_cur_idx, w_cell_idx;
  logic               w_in_grid, w_active, w_on_outline, w_outline_en;
  logic               w_mv_l, w_mv_r, w_mv_u, w_mv_d;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .PIX_DIV(PIX_DIV)
  ) u_timing (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .o_p_tick(w_tick), .o_frame_start(w_frame_start),
    .o_hsync(o_hsync), .o_vsync(o_vsync), .o_video_on(o_video_on),
    .o_x(o_x), .o_y(o_y), .o_h_cnt(w_h), .o_v_cnt(w_v)
  );

  // Cell column/offset follow the raw H/V counters so no divide is needed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gcol <= '0; r_goff <= '0; r_grow <= '0; r_roff <= '0;
    end else if (w_tick) begin
      if (w_h == H_LAST) begin
        r_gcol <= '0;
        r_goff <= '0;
        if (w_v == V_LAST) begin
          r_grow <= '0;
          r_roff <= '0;
        end else if (r_roff == CH_LAST) begin
          r_roff <= '0;
          r_grow <= r_grow + 1'b1;
        end else begin
          r_roff <= r_roff + 1'b1;
        end
      end else if (r_goff == CW_LAST) begin
        r_goff <= '0;
        r_gcol <= r_gcol + 1'b1;
      end else begin
        r_goff <= r_goff + 1'b1;
      end
    end
  end

`ifdef VGA_GRID_BLINK_EN
  logic [4:0] r_blink;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)           r_blink <= '0;
    else if (w_frame_start) r_blink <= r_blink + 1'b1;
  end
  assign w_outline_en = ~r_blink[4];
`else
  assign w_outline_en = 1'b1;
`endif

  assign w_in_grid  = (w_h < GRID_WP) && (w_v < GRID_HP);
  assign w_active   = (w_h < H_ACT) && (w_v < V_ACT);
  assign w_cell_idx = IDX_W'(r_grow) * IDX_W'(GRID_COLS) + IDX_W'(r_gcol);
  assign w_on_outline = (r_gcol == COORD_W'(r_disp_col)) && (r_grow == COORD_W'(r_disp_row)) &&
                        ((r_goff < BRD) || (r_goff >= CW_HI) || (r_roff < BRD) || (r_roff >= CH_HI));

  always_comb begin
    w_pix = BG_COLOR;
    if (w_in_grid) begin
      if (w_on_outline && w_outline_en) w_pix = CURSOR_COLOR;
      else                              w_pix = r_tab[w_cell_idx];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_rgb <= '0;
    else if (w_tick) r_rgb <= w_active ? w_pix : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_CELLS; i++) r_tab[i] <= '0;
    end else if (i_cell_we && (32'(i_cell_idx) < N_CELLS)) begin
      r_tab[i_cell_idx] <= i_cell_color;
    end
  end

  // Opposing pulses in the same cycle cancel on that axis.
  assign w_mv_l = i_left & ~i_right;
  assign w_mv_r = i_right & ~i_left;
  assign w_mv_u = i_up & ~i_down;
  assign w_mv_d = i_down & ~i_up;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col <= '0; r_row <= '0; r_disp_col <= '0; r_disp_row <= '0;
    end else begin
      if (w_mv_l)      r_col <= (r_col == '0) ? COL_LAST : r_col - 1'b1;
      else if (w_mv_r) r_col <= (r_col == COL_LAST) ? '0 : r_col + 1'b1;
      if (w_mv_u)      r_row <= (r_row == '0) ? ROW_LAST : r_row - 1'b1;
      else if (w_mv_d) r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
      if (w_frame_start) begin
        r_disp_col <= r_col;
        r_disp_row <= r_row;
      end
    end
  end

  // Handshake: o_sel_valid holds with o_sel_idx stable until a cycle with
  // o_sel_valid & i_sel_ready; completion beats a coincident i_sel.
  assign w_cur_idx = IDX_W'(r_row) * IDX_W'(GRID_COLS) + IDX_W'(r_col);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sel_valid <= 1'b0;
      r_sel_idx   <= '0;
    end else if (r_sel_valid && i_sel_ready) begin
      r_sel_valid <= 1'b0;
    end else if (i_sel && !r_sel_valid) begin
      r_sel_valid <= 1'b1;
      r_sel_idx   <= w_cur_idx;
    end
  end

  assign o_p_tick      = w_tick;
  assign o_frame_start = w_frame_start;
  assign o_rgb         = r_rgb;
  assign o_cursor_col  = r_col;
  assign o_cursor_row  = r_row;
  assign o_sel_valid   = r_sel_valid;
  assign o_sel_idx     = r_sel_idx;
endmodule

// File: tb/tb_vga_grid_engine.sv
// Directed bench for vga_grid_engine on a reduced raster (20x15 total, 14x11 active,
// 3x3 grid of 4x3 cells, 1-pixel outline, PIX_DIV=2) so whole frames fit in a short run.
module tb_vga_grid_engine;
  localparam logic [11:0] CUR = 12'hFFF;
  localparam logic [11:0] BG  = 12'h00F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0, sel = 1'b0;
  logic        cell_we = 1'b0, sel_ready = 1'b0;
  logic [3:0]  cell_idx = '0;
  logic [11:0] cell_color = '0;
  logic        hsync, vsync, video_on, p_tick, frame_start, sel_valid;
  logic [9:0]  x, y;
  logic [11:0] rgb;
  logic [1:0]  cur_col, cur_row;
  logic [3:0]  sel_idx;

  int n_checks = 0;
  int n_errors = 0;

  vga_grid_engine #(
    .H_ACTIVE(14), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(11), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .PIX_DIV(2), .GRID_COLS(3), .GRID_ROWS(3), .CELL_W(4), .CELL_H(3),
    .BORDER(1), .RGB_W(12), .CURSOR_COLOR(CUR), .BG_COLOR(BG)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_left(left), .i_right(right), .i_up(up), .i_down(down), .i_sel(sel),
    .i_cell_we(cell_we), .i_cell_idx(cell_idx), .i_cell_color(cell_color),
    .i_sel_ready(sel_ready),
    .o_hsync(hsync), .o_vsync(vsync), .o_video_on(video_on), .o_p_tick(p_tick),
    .o_frame_start(frame_start), .o_x(x), .o_y(y), .o_rgb(rgb),
    .o_cursor_col(cur_col), .o_cursor_row(cur_row),
    .o_sel_valid(sel_valid), .o_sel_idx(sel_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; holds the pulses for one clock and returns at the next negedge.
  task automatic pulse(input logic l, input logic r, input logic u, input logic d,
                       input logic s, input logic rdy);
    left = l; right = r; up = u; down = d; sel = s; sel_ready = rdy;
    @(negedge clk);
    left = 0; right = 0; up = 0; down = 0; sel = 0; sel_ready = 0;
  endtask

  task automatic write_cell(input logic [3:0] idx, input logic [11:0] color);
    cell_we = 1'b1; cell_idx = idx; cell_color = color;
    @(negedge clk);
    cell_we = 1'b0;
  endtask

  task automatic wait_pix(input int px, input int py);
    int n = 0;
    while (!(int'(x) == px && int'(y) == py) && n < 1500) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("reach_%0d_%0d", px, py), 32'(int'(x) == px && int'(y) == py), 1);
  endtask

  task automatic check_pix(input int px, input int py, input logic [11:0] exp);
    wait_pix(px, py);
    check($sformatf("rgb_%0d_%0d", px, py), rgb, exp);
  endtask

  task automatic wait_frame();
    int n = 0;
    while (frame_start !== 1'b1 && n < 1500) begin
      @(negedge clk);
      n++;
    end
    check("frame_start_seen", frame_start, 1);
    @(negedge clk);
  endtask

  function automatic logic sync_now(input bit vert);
    return vert ? vsync : hsync;
  endfunction

  task automatic measure(input bit vert, output int low, output int period);
    int n = 0;
    low = 0;
    period = 0;
    while (sync_now(vert) !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
    while (sync_now(vert) !== 1'b0 && n < 4000) begin @(negedge clk); n++; end
    while (sync_now(vert) === 1'b0 && n < 4000) begin @(negedge clk); n++; low++; period++; end
    while (sync_now(vert) === 1'b1 && n < 4000) begin @(negedge clk); n++; period++; end
  endtask

  initial begin
    int lo, per, ticks;
    // clock/reset
    repeat (3) @(negedge clk);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_video_on", video_on, 0);
    check("rst_rgb", rgb, 0);
    check("rst_xy", {x, y}, 0);
    check("rst_p_tick", p_tick, 0);
    check("rst_cursor", {cur_col, cur_row}, 0);
    check("rst_sel", {sel_valid, sel_idx}, 0);
    rst_n = 1'b1;

    ticks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (p_tick) ticks++;
    end
    check("p_tick_rate", ticks, 4);

    measure(1'b0, lo, per);
    check("hsync_low", lo, 6);
    check("hsync_period", per, 40);
    measure(1'b1, lo, per);
    check("vsync_low", lo, 80);
    check("vsync_period", per, 600);

    // cursor wrap and cancellation
    pulse(1, 0, 0, 0, 0, 0); check("cur_left_wrap", {cur_col, cur_row}, {2'd2, 2'd0});
    pulse(0, 0, 1, 0, 0, 0); check("cur_up_wrap",   {cur_col, cur_row}, {2'd2, 2'd2});
    pulse(1, 1, 0, 0, 0, 0); check("cur_lr_cancel", {cur_col, cur_row}, {2'd2, 2'd2});
    pulse(0, 1, 0, 1, 0, 0); check("cur_diag_wrap", {cur_col, cur_row}, {2'd0, 2'd0});
    pulse(0, 1, 0, 1, 0, 0); check("cur_to_11",     {cur_col, cur_row}, {2'd1, 2'd1});

    // colour table and rendering
    write_cell(4'd4, 12'hF00);
    write_cell(4'd8, 12'h0F0);
    write_cell(4'd9, 12'h0AA);
    wait_frame();
    check("frame_start_xy", {x, y}, {10'd0, 10'd11});
    check_pix(12, 0, BG);
    check_pix(1, 1, 12'h000);
    check_pix(4, 3, CUR);
    check_pix(5, 4, 12'hF00);
    check_pix(7, 4, CUR);
    check_pix(9, 7, 12'h0F0);
    check_pix(13, 10, BG);
    check("video_on_visible", video_on, 1);
    wait_pix(16, 10);
    check("video_on_blank", video_on, 0);
    check("rgb_blank", rgb, 0);

    // mid-frame cursor move must not tear
    wait_pix(0, 4);
    pulse(0, 1, 0, 1, 0, 0);
    check("cur_to_22", {cur_col, cur_row}, {2'd2, 2'd2});
    check_pix(4, 5, CUR);
    check_pix(8, 6, 12'h0F0);
    wait_frame();
    check_pix(4, 3, 12'hF00);
    check_pix(8, 6, CUR);

    // select handshake
    pulse(0, 0, 1, 0, 0, 0);
    pulse(0, 0, 0, 0, 1, 0);
    check("sel_first", {sel_valid, sel_idx}, {1'b1, 4'd5});
    pulse(1, 0, 0, 0, 0, 0);
    pulse(0, 0, 0, 0, 1, 0);
    check("sel_dropped", {sel_valid, sel_idx}, {1'b1, 4'd5});
    pulse(0, 0, 0, 0, 0, 1);
    check("sel_complete", sel_valid, 0);
    pulse(0, 0, 0, 0, 1, 0);
    check("sel_second", {sel_valid, sel_idx}, {1'b1, 4'd4});
    pulse(0, 0, 0, 0, 1, 1);
    check("sel_complete_wins", sel_valid, 0);
    @(negedge clk);
    check("sel_stays_idle", sel_valid, 0);
    pulse(0, 0, 0, 0, 1, 0);

    // asynchronous reset mid-frame
    wait_pix(5, 4);
    #1 rst_n = 1'b0;
    #1;
    check("arst_sync", {hsync, vsync}, 2'b11);
    check("arst_video", {video_on, p_tick, frame_start}, 0);
    check("arst_rgb", rgb, 0);
    check("arst_xy", {x, y}, 0);
    check("arst_cursor", {cur_col, cur_row}, 0);
    check("arst_sel", {sel_valid, sel_idx}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check_pix(1, 0, CUR);
    check_pix(5, 4, 12'h000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/vga_grid_engine.md
Name: vga_grid_engine

Overview:
Parametrised VGA timing generator plus grid renderer for the chimp-test display path. Generalises the fixed 640x480, 3x3 grid to configurable timing, grid dimensions, cell size and colour width. Adds a cell colour table, a wrap-around cursor driven by debounced button pulses, and a valid/ready select handshake toward the game logic. Sits between the debouncers and the board VGA pins, replacing the separate sync unit and hard-coded grid colouring.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in pixels
V_ACTIVE, 480, visible lines
V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
PIX_DIV, 4, clk cycles per pixel (100 MHz clk gives a 25 MHz pixel rate)
GRID_COLS / GRID_ROWS, 3 / 3, grid dimensions
CELL_W / CELL_H, 213 / 160, cell size in pixels
BORDER, 2, cursor outline thickness in pixels
RGB_W, 12, colour width
CURSOR_COLOR / BG_COLOR, 12'hFFF / 12'h000, cursor outline colour and outside-grid colour

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
left/right/up/down  in  1 each  single-cycle debounced pulses
sel  in  1  single-cycle debounced pulse
cell_we  in  1  colour table write strobe
cell_idx  in  IDX_W  write index, row*GRID_COLS+col, where IDX_W=$clog2(GRID_COLS*GRID_ROWS)
cell_color  in  RGB_W  write data
sel_ready  in  1  consumer accepts selection
hsync/vsync  out  1  active-low sync signals
video_on  out  1  visible region
p_tick  out  1  pixel strobe, one clk cycle wide
frame_start  out  1  one-clk pulse on the first pixel tick of line V_ACTIVE, column 0
x/y  out  10  current pixel coordinates
rgb  out  RGB_W  pixel colour, 0 when video_on=0
cursor_col/cursor_row  out  clog2 widths  live cursor position
sel_valid  out  1  selection pending
sel_idx  out  IDX_W  selected cell index

Behaviour:
- Reset (async assert, sync release) sets outputs as follows:
  - hsync=vsync=1; video_on, p_tick, frame_start, rgb, x, y = 0.
  - Cursor position 0,0; sel_valid=0; sel_idx=0.
  - All colour table entries = 0; blink counter = 0.
- Pixel divider:
  - Counts 0..PIX_DIV-1; p_tick=1 on the cycle where the count equals PIX_DIV-1.
  - H counter 0..H_TOTAL-1 advances on p_tick; V counter advances when H wraps and itself wraps at V_TOTAL-1.
- Syncs:
  - hsync=0 for H in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vsync=0 for V in the equivalent vertical range.
- Output alignment: hsync, vsync, video_on, x, y and rgb are all registered on p_tick and mutually aligned (one-stage pipeline). There is no division in the pixel path.
- Grid position tracking:
  - Column/offset counters track the grid position incrementally. The offset wraps at CELL_W-1 and the column increments; both reset at H=0. Rows are tracked the same way per line.
  - A pixel is outside the grid when x >= GRID_COLS*CELL_W or y >= GRID_ROWS*CELL_H.
- Colour priority:
  1. Outside grid: BG_COLOR.
  2. Inside the displayed-cursor cell with offset < BORDER or offset >= CELL-BORDER (either axis): CURSOR_COLOR.
  3. Otherwise: the colour table entry for that cell.
- Cursor movement:
  - Updates on the clk cycle after a pulse.
  - left at col 0 wraps to GRID_COLS-1 and right at the last column wraps to 0; rows behave the same way.
  - left&right together gives no horizontal move; up&down together gives no vertical move. One horizontal and one vertical pulse together give a diagonal move.
- Displayed cursor: a shadow copy of the live cursor, loaded only on frame_start, so no tearing occurs mid-frame.
- Select handshake:
  - When sel=1 and sel_valid=0: next cycle sel_valid=1 and sel_idx = live cursor index.
  - sel pulses while sel_valid=1 are dropped.
  - sel_valid clears the cycle after sel_valid&sel_ready. If sel and a handshake completion coincide, the completion wins and the sel is dropped.
- Colour table writes:
  - Take effect the next cycle.
  - Writes with cell_idx >= GRID_COLS*GRID_ROWS are ignored.

Optional Feature:
VGA_GRID_BLINK_EN:
- Defined: a 5-bit frame counter increments on frame_start. The cursor outline is drawn only while bit 4 = 0 (16 frames on, 16 frames off); while off, those pixels show the cell colour. Counter resets to 0.
- Undefined: the outline is steady and no counter is present.

Decomposition:
- Package vga_grid_pkg holds:
  - H_TOTAL/V_TOTAL derivation;
  - sync start/end constants;
  - IDX_W and coordinate-width localparams;
  - default colours.
- Natural sub-module: vga_timing_gen, containing the divider, H/V counters, syncs, video_on and frame_start. The top-level adds grid tracking, colour table, cursor and handshake.

Test Plan:
1. Release rst -> hsync=vsync=1, rgb=0. hsync has a period of 3200 clk and a low time of 384 clk. vsync has a period of 1,680,000 clk and a low time of 6400 clk.
2. From cursor (0,0): left -> col 2; then up -> row 2; then left+right in the same cycle -> stays (2,2); then right+down -> (0,0).
3. Write cell_idx=4 with 12'hF00 and hold the cursor at (1,1) through frame_start. Expected rgb: pixel (300,200)=F00; (213,160)=CURSOR_COLOR; (639,479)=BG_COLOR (x=639 is outside the grid).
4. Cursor at (2,1) and sel pulse -> sel_valid=1, sel_idx=5 next cycle. A second sel with sel_ready=0 is ignored. One-cycle sel_ready -> sel_valid=0 on the following cycle.
5. Move the cursor at line 100 -> rendered outline unchanged for the rest of the frame and in the new cell after frame_start. rst asserted mid-frame -> all outputs return to reset values immediately.
6. With VGA_GRID_BLINK_EN defined -> outline present for frames 0-15, absent for frames 16-31, present again at frame 32.
